// File: rtl/r5p_wbu_mc.sv
// Multi-channel GPR write-back unit: fixed-latency decode path plus CHN in-order result channels.
// Optional macro R5P_WBU_BYPASS_EN adds a combinational forwarding port from the write-back registers.
module r5p_wbu_mc #(
   parameter  int XLEN = 32,
   parameter  int CHN  = 2,
   parameter  int DEP  = 2,
   localparam int SW   = $clog2(CHN+1)
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                dec_vld,
   output logic                dec_rdy,
   input  logic                dec_wen,
   input  logic [4:0]          dec_rd,
   input  logic [SW-1:0]       dec_sel,
   input  logic [XLEN-1:0]     dec_dat,
   input  logic [CHN-1:0]      chn_vld,
   output logic [CHN-1:0]      chn_rdy,
   input  logic [CHN*XLEN-1:0] chn_dat,
   output logic [31:0]         busy,
   output logic                err,
   output logic                wen,
   output logic [4:0]          adr,
   output logic [XLEN-1:0]     dat
`ifdef R5P_WBU_BYPASS_EN
   ,
   input  logic [4:0]          rs1,
   input  logic [4:0]          rs2,
   output logic                fw1_vld,
   output logic                fw2_vld,
   output logic [XLEN-1:0]     fw1_dat,
   output logic [XLEN-1:0]     fw2_dat
`endif
);

   localparam int PW = $clog2(DEP) + 1;
   localparam int AW = (DEP > 1) ? $clog2(DEP) : 1;

   // Each tag entry is {wen_eff, rd}
   logic [5:0]      mem [CHN][DEP];
   logic [PW-1:0]   wp  [CHN];
   logic [PW-1:0]   rp  [CHN];

   logic [CHN-1:0]  empty;
   logic [CHN-1:0]  full;
   logic [CHN-1:0]  elig;
   logic [CHN-1:0]  gnt;
   logic [CHN-1:0]  push;
   logic            chn_acc;
   logic [5:0]      head;
   logic [XLEN-1:0] gdat;
   logic            dec_wen_eff;
   logic            tgt_ok;
   logic            tgt_full;
   logic            haz;
   logic            dec_acc;
   logic            err_set;
   logic [31:0]     set_vec;
   logic [31:0]     clr_vec;

   function automatic logic [AW-1:0] idx(input logic [PW-1:0] p);
      if (DEP > 1) return AW'(p);
      else         return '0;
   endfunction

   always_comb begin
      empty    = '0;
      full     = '0;
      head     = '0;
      gdat     = '0;
      tgt_full = 1'b0;
      push     = '0;
      set_vec  = '0;
      clr_vec  = '0;
      err_set  = 1'b0;

      for (int k = 0; k < CHN; k++) begin
         empty[k] = (wp[k] == rp[k]);
         // Wrapped pointers: full when only the extra MSB differs
         full[k]  = ((wp[k] ^ rp[k]) == PW'(DEP));
      end

      // A result on a channel with no pending tag is dropped and flagged
      elig    = chn_vld & ~empty;
      gnt     = elig & (~elig + CHN'(1));
      chn_acc = |gnt;
      chn_rdy = gnt;

      for (int k = 0; k < CHN; k++) begin
         if (gnt[k]) begin
            head = mem[k][idx(rp[k])];
            gdat = chn_dat[k*XLEN +: XLEN];
         end
         if (dec_sel == SW'(k+1) && full[k]) tgt_full = 1'b1;
      end

      dec_wen_eff = dec_wen & (dec_rd != 5'd0);
      tgt_ok      = (dec_sel != '0) && (int'(dec_sel) <= CHN);
      haz         = dec_wen_eff & busy[dec_rd];
      dec_rdy     = ~chn_acc & ~tgt_full & ~haz;
      dec_acc     = dec_vld & dec_rdy;

      for (int k = 0; k < CHN; k++) begin
         push[k] = dec_acc && (dec_sel == SW'(k+1));
         if (chn_vld[k] && empty[k]) err_set = 1'b1;
      end
      if (dec_vld && int'(dec_sel) > CHN) err_set = 1'b1;

      if (dec_acc && tgt_ok && dec_wen_eff) set_vec[dec_rd]  = 1'b1;
      if (chn_acc && head[5])               clr_vec[head[4:0]] = 1'b1;
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < CHN; k++) begin
         if (push[k]) mem[k][idx(wp[k])] <= {dec_wen_eff, dec_rd};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wen  <= 1'b0;
         adr  <= '0;
         dat  <= '0;
         busy <= '0;
         err  <= 1'b0;
         for (int k = 0; k < CHN; k++) begin
            wp[k] <= '0;
            rp[k] <= '0;
         end
      end else begin
         busy <= (busy & ~clr_vec) | set_vec;
         if (err_set) err <= 1'b1;
         for (int k = 0; k < CHN; k++) begin
            if (push[k]) wp[k] <= wp[k] + PW'(1);
            if (gnt[k])  rp[k] <= rp[k] + PW'(1);
         end
         if (chn_acc) begin
            wen <= head[5];
            adr <= head[4:0];
            dat <= gdat;
         end else if (dec_acc && dec_sel == '0) begin
            wen <= dec_wen_eff;
            adr <= dec_rd;
            dat <= dec_dat;
         end else begin
            wen <= 1'b0;
         end
      end
   end

`ifdef R5P_WBU_BYPASS_EN
   assign fw1_vld = wen && (adr == rs1) && (rs1 != 5'd0);
   assign fw2_vld = wen && (adr == rs2) && (rs2 != 5'd0);
   assign fw1_dat = dat;
   assign fw2_dat = dat;
`endif

endmodule

// File: tb/tb_r5p_wbu_mc.sv
// Self-checking bench for r5p_wbu_mc: directed scenarios followed by randomized traffic
// against a queue-based reference model of the write-back unit.
module tb_r5p_wbu_mc;

   localparam int XLEN = 32;
   localparam int CHN  = 2;
   localparam int DEP  = 2;
   localparam int SW   = $clog2(CHN+1);

   logic                clk = 1'b0;
   logic                rst;
   logic                dec_vld;
   logic                dec_rdy;
   logic                dec_wen;
   logic [4:0]          dec_rd;
   logic [SW-1:0]       dec_sel;
   logic [XLEN-1:0]     dec_dat;
   logic [CHN-1:0]      chn_vld;
   logic [CHN-1:0]      chn_rdy;
   logic [CHN*XLEN-1:0] chn_dat;
   logic [31:0]         busy;
   logic                err;
   logic                wen;
   logic [4:0]          adr;
   logic [XLEN-1:0]     dat;
`ifdef R5P_WBU_BYPASS_EN
   logic [4:0]          rs1 = '0;
   logic [4:0]          rs2 = '0;
   logic                fw1_vld, fw2_vld;
   logic [XLEN-1:0]     fw1_dat, fw2_dat;
`endif

   always #5 clk = ~clk;

   r5p_wbu_mc #(.XLEN(XLEN), .CHN(CHN), .DEP(DEP)) dut (
      .clk(clk), .rst(rst),
      .dec_vld(dec_vld), .dec_rdy(dec_rdy), .dec_wen(dec_wen), .dec_rd(dec_rd),
      .dec_sel(dec_sel), .dec_dat(dec_dat),
      .chn_vld(chn_vld), .chn_rdy(chn_rdy), .chn_dat(chn_dat),
      .busy(busy), .err(err), .wen(wen), .adr(adr), .dat(dat)
`ifdef R5P_WBU_BYPASS_EN
      , .rs1(rs1), .rs2(rs2), .fw1_vld(fw1_vld), .fw2_vld(fw2_vld),
      .fw1_dat(fw1_dat), .fw2_dat(fw2_dat)
`endif
   );

   // Reference model: per-channel queues of pending {wen_eff, rd}
   logic [5:0]      mq [CHN][$];
   logic            m_wen;
   logic            m_err;
   logic [4:0]      m_adr;
   logic [XLEN-1:0] m_dat;
   logic [XLEN+4:0] exp_q [$];
   int              n_tests = 0;
   int              n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_busy();
      logic [31:0] b;
      b = '0;
      for (int k = 0; k < CHN; k++)
         for (int i = 0; i < mq[k].size(); i++)
            if (mq[k][i][5]) b[mq[k][i][4:0]] = 1'b1;
      return b;
   endfunction

   task automatic m_reset();
      for (int k = 0; k < CHN; k++) mq[k].delete();
      exp_q.delete();
      m_wen = 1'b0;
      m_adr = '0;
      m_dat = '0;
      m_err = 1'b0;
   endtask

   task automatic set_dec(input logic v, input logic [SW-1:0] s, input logic [4:0] r,
                          input logic w, input logic [XLEN-1:0] d);
      dec_vld = v; dec_sel = s; dec_rd = r; dec_wen = w; dec_dat = d;
   endtask

   task automatic set_chn(input logic [CHN-1:0] v, input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1);
      chn_vld = v;
      chn_dat = {d1, d0};
   endtask

   task automatic idle();
      dec_vld = 1'b0;
      chn_vld = '0;
   endtask

   // One clock: check handshakes mid-cycle, advance the model, check registers after the edge
   task automatic step();
      int              g;
      int              s;
      logic [31:0]     b;
      logic [CHN-1:0]  e_rdy;
      logic            tgt_full, haz, rdy, acc;
      logic [5:0]      e;
      #2;
      b = m_busy();
      s = int'(dec_sel);
      g = -1;
      for (int k = 0; k < CHN; k++)
         if (g < 0 && chn_vld[k] && mq[k].size() > 0) g = k;
      e_rdy = '0;
      if (g >= 0) e_rdy[g] = 1'b1;
      tgt_full = 1'b0;
      if (s >= 1 && s <= CHN) tgt_full = (mq[s-1].size() == DEP);
      haz = dec_wen && dec_rd != 5'd0 && b[dec_rd];
      rdy = (g < 0) && !tgt_full && !haz;
      chk("chn_rdy", 64'(chn_rdy), 64'(e_rdy));
      chk("dec_rdy", 64'(dec_rdy), 64'(rdy));
      acc = rdy && dec_vld;

      if (!rst) begin
         m_reset();
      end else begin
         for (int k = 0; k < CHN; k++)
            if (chn_vld[k] && mq[k].size() == 0) m_err = 1'b1;
         if (dec_vld && s > CHN) m_err = 1'b1;
         if (g >= 0) begin
            e     = mq[g].pop_front();
            m_wen = e[5];
            m_adr = e[4:0];
            m_dat = chn_dat[g*XLEN +: XLEN];
         end else if (acc && s == 0) begin
            m_wen = dec_wen && dec_rd != 5'd0;
            m_adr = dec_rd;
            m_dat = dec_dat;
         end else begin
            m_wen = 1'b0;
            if (acc && s >= 1 && s <= CHN)
               mq[s-1].push_back({dec_wen && dec_rd != 5'd0, dec_rd});
         end
         if (m_wen) exp_q.push_back({m_adr, m_dat});
      end

      @(posedge clk);
      #1;
      chk("wen",  64'(wen),  64'(m_wen));
      chk("adr",  64'(adr),  64'(m_adr));
      chk("dat",  64'(dat),  64'(m_dat));
      chk("busy", 64'(busy), 64'(m_busy()));
      chk("err",  64'(err),  64'(m_err));
      if (wen) begin
         chk("wr_expected", 64'(exp_q.size() != 0), 64'(1));
         if (exp_q.size() != 0) chk("wr_order", 64'({adr, dat}), 64'(exp_q.pop_front()));
      end
   endtask

   initial begin
      rst = 1'b0;
      set_dec(1'b0, '0, 5'd0, 1'b0, '0);
      set_chn('0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      m_reset();
      chk("rst_wen",  64'(wen),  64'(0));
      chk("rst_adr",  64'(adr),  64'(0));
      chk("rst_dat",  64'(dat),  64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_err",  64'(err),  64'(0));
      rst = 1'b1;

      // Immediate result, latency 1
      set_dec(1'b1, 2'd0, 5'd5, 1'b1, 32'h1234); step();
      idle(); step();

      // Delayed write on channel 0 after two idle cycles
      set_dec(1'b1, 2'd1, 5'd7, 1'b1, '0); step();
      idle(); step(); step();
      set_chn(2'b01, 32'hCAFE, '0); step();
      idle(); step();

      // Both channels pending plus a decode: ch0, ch1, then decode
      set_dec(1'b1, 2'd1, 5'd10, 1'b1, '0); step();
      set_dec(1'b1, 2'd2, 5'd11, 1'b1, '0); step();
      set_dec(1'b1, 2'd0, 5'd12, 1'b1, 32'h12);
      set_chn(2'b11, 32'hA0, 32'hA1); step();
      chn_vld = 2'b10; step();
      chn_vld = 2'b00; step();
      idle(); step();

      // FIFO full stall, then in-order completion 1,2,3
      set_dec(1'b1, 2'd1, 5'd1, 1'b1, '0); step();
      set_dec(1'b1, 2'd1, 5'd2, 1'b1, '0); step();
      set_dec(1'b1, 2'd1, 5'd3, 1'b1, '0); step(); step();
      set_chn(2'b01, 32'hB1, '0); step();
      chn_vld = '0; step();
      dec_vld = 1'b0;
      set_chn(2'b01, 32'hB2, '0); step();
      set_chn(2'b01, 32'hB3, '0); step();
      idle(); step();

      // Hazard stall on rd 9, then a delayed write to x0
      set_dec(1'b1, 2'd1, 5'd9, 1'b1, '0); step();
      set_dec(1'b1, 2'd0, 5'd9, 1'b1, 32'h99); step(); step();
      set_chn(2'b01, 32'hC9, '0); step();
      chn_vld = '0; step();
      idle(); step();
      set_dec(1'b1, 2'd2, 5'd0, 1'b1, '0); step();
      idle(); step();
      set_chn(2'b10, '0, 32'hD0); step();
      idle(); step();

      // Error on empty channel, sticky, cleared by reset; bad selector
      set_chn(2'b10, '0, 32'hEE); step();
      idle(); step(); step();
      rst = 1'b0; step();
      rst = 1'b1; step();
      set_dec(1'b1, 2'd3, 5'd4, 1'b1, 32'h44); step();
      idle(); step();
      rst = 1'b0; step();
      rst = 1'b1; step();

      // Randomized traffic; channels only present results that have a pending tag
      for (int c = 0; c < 3000; c++) begin
         rst     = ($urandom_range(0, 199) != 0);
         dec_vld = 1'($urandom_range(0, 1));
         dec_wen = ($urandom_range(0, 3) != 0);
         dec_rd  = 5'($urandom_range(0, 7));
         dec_sel = SW'($urandom_range(0, CHN));
         dec_dat = $urandom;
         for (int k = 0; k < CHN; k++) begin
            chn_vld[k]               = ($urandom_range(0, 2) == 0) && (mq[k].size() > 0);
            chn_dat[k*XLEN +: XLEN] = $urandom;
         end
         step();
      end

      // Drain whatever is still pending
      rst = 1'b1;
      dec_vld = 1'b0;
      for (int c = 0; c < 3 * DEP * CHN; c++) begin
         for (int k = 0; k < CHN; k++) chn_vld[k] = (mq[k].size() > 0);
         step();
      end
      chk("drain_busy", 64'(busy), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
